// File: rtl/mux_uart_pkg.sv
// Shared constants and state encodings for the multi-channel MUX UART.
// Status register bit positions, serial frame length and the TX/RX FSM state enums.
package mux_uart_pkg;

    localparam int unsigned ST_RX_READY    = 0;
    localparam int unsigned ST_TX_READY    = 1;
    localparam int unsigned ST_TX_IDLE     = 2;
    localparam int unsigned ST_RX_OVERRUN  = 3;
    localparam int unsigned ST_TX_OVERFLOW = 4;
    localparam int unsigned ST_RX_FRAMING  = 5;

    // 8N1: start + 8 data + stop
    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned DATA_BITS  = FRAME_BITS - 2;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/mux_uart_channel.sv
// One serial channel: TX FIFO, TX shifter FSM, sticky flags and (with MUX_UART_RX_EN)
// the receiver with synchronizer and holding register.
module mux_uart_channel
    import mux_uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       i_wr_status,
    input  logic       i_wr_data,
    input  logic [7:0] i_wdata,
    input  logic       i_rx,
    output logic       o_tx,
    output logic [7:0] o_status_c,
    output logic [7:0] o_rx_data
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_overflow_set;
    logic [7:0]      w_fifo_head;
    logic [7:0]      w_clr;

    tx_state_e       r_tx_state;
    tx_state_e       w_tx_state_nxt;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [CNT_W-1:0] w_tx_cnt_nxt;
    logic [2:0]      r_tx_bit;
    logic [2:0]      w_tx_bit_nxt;
    logic [7:0]      r_tx_shift;
    logic [7:0]      w_tx_shift_nxt;
    logic            r_tx;
    logic            w_tx_nxt;
    logic            w_tx_bit_end;
    logic            r_tx_overflow;

    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign w_push         = i_wr_data && (!w_full || w_pop);
    assign w_overflow_set = i_wr_data && w_full && !w_pop;
    assign w_fifo_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_clr          = i_wr_status ? i_wdata : 8'h00;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    assign w_tx_bit_end = (r_tx_cnt == CNT_W'(CLKS_PER_BIT - 1));

    // TX next-state: stop bit chains straight into the next start bit when data is queued.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = (r_tx_state == TX_IDLE || w_tx_bit_end) ? '0 : r_tx_cnt + CNT_W'(1);
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_nxt       = r_tx;
        w_pop          = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (!w_empty) begin
                    w_pop          = 1'b1;
                    w_tx_shift_nxt = w_fifo_head;
                    w_tx_nxt       = 1'b0;
                    w_tx_state_nxt = TX_START;
                end
            end
            TX_START: begin
                if (w_tx_bit_end) begin
                    w_tx_nxt       = r_tx_shift[0];
                    w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
                    w_tx_bit_nxt   = '0;
                    w_tx_state_nxt = TX_DATA;
                end
            end
            TX_DATA: begin
                if (w_tx_bit_end) begin
                    if (r_tx_bit == 3'(DATA_BITS - 1)) begin
                        w_tx_nxt       = 1'b1;
                        w_tx_state_nxt = TX_STOP;
                    end else begin
                        w_tx_nxt       = r_tx_shift[0];
                        w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
                        w_tx_bit_nxt   = r_tx_bit + 3'(1);
                    end
                end
            end
            TX_STOP: begin
                if (w_tx_bit_end) begin
                    if (!w_empty) begin
                        w_pop          = 1'b1;
                        w_tx_shift_nxt = w_fifo_head;
                        w_tx_nxt       = 1'b0;
                        w_tx_state_nxt = TX_START;
                    end else begin
                        w_tx_state_nxt = TX_IDLE;
                    end
                end
            end
            default: begin
                w_tx_nxt       = 1'b1;
                w_tx_state_nxt = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_state    <= TX_IDLE;
            r_tx_cnt      <= '0;
            r_tx_bit      <= '0;
            r_tx_shift    <= '0;
            r_tx          <= 1'b1;
            r_tx_overflow <= 1'b0;
        end else begin
            r_tx_state    <= w_tx_state_nxt;
            r_tx_cnt      <= w_tx_cnt_nxt;
            r_tx_bit      <= w_tx_bit_nxt;
            r_tx_shift    <= w_tx_shift_nxt;
            r_tx          <= w_tx_nxt;
            r_tx_overflow <= (r_tx_overflow & ~w_clr[ST_TX_OVERFLOW]) | w_overflow_set;
        end
    end

    assign o_tx = r_tx;

`ifdef MUX_UART_RX_EN
    logic [1:0]       r_rx_sync;
    logic             r_rx_prev;
    logic             w_rx_s;
    logic             w_rx_fall;
    rx_state_e        r_rx_state;
    rx_state_e        w_rx_state_nxt;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [CNT_W-1:0] w_rx_cnt_nxt;
    logic [2:0]       r_rx_bit;
    logic [2:0]       w_rx_bit_nxt;
    logic [7:0]       r_rx_shift;
    logic [7:0]       w_rx_shift_nxt;
    logic             w_rx_sample;
    logic             w_rx_done;
    logic [7:0]       r_rx_hold;
    logic             r_rx_ready;
    logic             r_rx_overrun;
    logic             r_rx_framing;

    assign w_rx_s    = r_rx_sync[1];
    assign w_rx_fall = r_rx_prev && !w_rx_s;
    // Start bit is checked mid-bit; every later sample is one full bit period on.
    assign w_rx_sample = (r_rx_state == RX_START) ? (r_rx_cnt == CNT_W'(CLKS_PER_BIT / 2 - 1))
                                                  : (r_rx_cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = (r_rx_state == RX_IDLE || w_rx_sample) ? '0 : r_rx_cnt + CNT_W'(1);
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_done      = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (w_rx_fall) w_rx_state_nxt = RX_START;
            end
            RX_START: begin
                if (w_rx_sample) begin
                    w_rx_bit_nxt   = '0;
                    w_rx_state_nxt = w_rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_rx_sample) begin
                    w_rx_shift_nxt = {w_rx_s, r_rx_shift[7:1]};
                    w_rx_bit_nxt   = r_rx_bit + 3'(1);
                    if (r_rx_bit == 3'(DATA_BITS - 1)) w_rx_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_rx_sample) begin
                    w_rx_done      = 1'b1;
                    w_rx_state_nxt = RX_IDLE;
                end
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_sync    <= 2'b11;
            r_rx_prev    <= 1'b1;
            r_rx_state   <= RX_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_rx_hold    <= '0;
            r_rx_ready   <= 1'b0;
            r_rx_overrun <= 1'b0;
            r_rx_framing <= 1'b0;
        end else begin
            r_rx_sync    <= {r_rx_sync[0], i_rx};
            r_rx_prev    <= w_rx_s;
            r_rx_state   <= w_rx_state_nxt;
            r_rx_cnt     <= w_rx_cnt_nxt;
            r_rx_bit     <= w_rx_bit_nxt;
            r_rx_shift   <= w_rx_shift_nxt;
            if (w_rx_done) r_rx_hold <= r_rx_shift;
            r_rx_ready   <= (r_rx_ready   & ~w_clr[ST_RX_READY])   | w_rx_done;
            r_rx_overrun <= (r_rx_overrun & ~w_clr[ST_RX_OVERRUN]) | (w_rx_done & r_rx_ready);
            r_rx_framing <= (r_rx_framing & ~w_clr[ST_RX_FRAMING]) | (w_rx_done & ~w_rx_s);
        end
    end

    assign o_rx_data = r_rx_hold;

    always_comb begin
        o_status_c                 = 8'h00;
        o_status_c[ST_RX_READY]    = r_rx_ready;
        o_status_c[ST_TX_READY]    = !w_full;
        o_status_c[ST_TX_IDLE]     = w_empty && (r_tx_state == TX_IDLE);
        o_status_c[ST_RX_OVERRUN]  = r_rx_overrun;
        o_status_c[ST_TX_OVERFLOW] = r_tx_overflow;
        o_status_c[ST_RX_FRAMING]  = r_rx_framing;
    end
`else
    logic w_unused_rx;
    assign w_unused_rx = i_rx;
    assign o_rx_data   = 8'h00;

    always_comb begin
        o_status_c                 = 8'h00;
        o_status_c[ST_TX_READY]    = !w_full;
        o_status_c[ST_TX_IDLE]     = w_empty && (r_tx_state == TX_IDLE);
        o_status_c[ST_TX_OVERFLOW] = r_tx_overflow;
    end
`endif

endmodule

// File: rtl/mux_uart.sv
// CPU6 memory-mapped MUX UART: address decode, combinational read mux and CHANNELS
// channel instances. Define MUX_UART_RX_EN to build the receivers.
module mux_uart
    import mux_uart_pkg::*;
#(
    parameter logic [18:0] BASE_ADDR    = 19'h3f200,
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [18:0]         address,
    input  logic                write_en,
    input  logic [7:0]          data_in,
    output logic [7:0]          data_out,
    output logic                hit,
    output logic [CHANNELS-1:0] tx,
    input  logic [CHANNELS-1:0] rx
);

    localparam int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned OFF_W     = CH_W + 1;
    localparam logic [18:0] LAST_ADDR = BASE_ADDR + 19'(2 * CHANNELS - 1);

    logic [OFF_W-1:0]    w_offset;
    logic [CH_W-1:0]     w_sel;
    logic                w_is_data;
    logic [CHANNELS-1:0] w_wr_status;
    logic [CHANNELS-1:0] w_wr_data;
    logic [7:0]          w_status  [CHANNELS];
    logic [7:0]          w_rx_data [CHANNELS];

    assign hit       = (address >= BASE_ADDR) && (address <= LAST_ADDR);
    assign w_offset  = OFF_W'(address - BASE_ADDR);
    assign w_sel     = w_offset[OFF_W-1:1];
    assign w_is_data = w_offset[0];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign w_wr_status[g] = write_en && hit && (w_sel == CH_W'(g)) && !w_is_data;
        assign w_wr_data[g]   = write_en && hit && (w_sel == CH_W'(g)) &&  w_is_data;

        mux_uart_channel #(
            .FIFO_DEPTH   (FIFO_DEPTH),
            .CLKS_PER_BIT (CLKS_PER_BIT)
        ) u_channel (
            .clock       (clock),
            .reset_n     (reset_n),
            .i_wr_status (w_wr_status[g]),
            .i_wr_data   (w_wr_data[g]),
            .i_wdata     (data_in),
            .i_rx        (rx[g]),
            .o_tx        (tx[g]),
            .o_status_c  (w_status[g]),
            .o_rx_data   (w_rx_data[g])
        );
    end

    // Read data is zero whenever the address falls outside the block.
    always_comb begin
        data_out = 8'h00;
        if (hit) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_sel == CH_W'(c)) begin
                    data_out = w_is_data ? w_rx_data[c] : w_status[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_uart.sv
// Directed self-checking bench for mux_uart (4 channels, depth 16, 16 clocks/bit).
// Receiver steps run only when MUX_UART_RX_EN is defined.
module tb_mux_uart;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [18:0] address;
    logic        write_en;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        hit;
    logic [3:0]  tx;
    logic [3:0]  rx;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    mux_uart #(
        .BASE_ADDR    (19'h3f200),
        .CHANNELS     (4),
        .FIFO_DEPTH   (16),
        .CLKS_PER_BIT (16)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .address  (address),
        .write_en (write_en),
        .data_in  (data_in),
        .data_out (data_out),
        .hit      (hit),
        .tx       (tx),
        .rx       (rx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [18:0] a, input logic [7:0] d);
        address  = a;
        data_in  = d;
        write_en = 1'b1;
        @(posedge clock);
        #1;
        write_en = 1'b0;
    endtask

    task automatic bus_read(input logic [18:0] a, output logic [7:0] d, output logic h);
        address = a;
        #1;
        d = data_out;
        h = hit;
    endtask

`ifdef MUX_UART_RX_EN
    task automatic send_rx(input int ch, input logic [7:0] b, input logic stop_bit);
        rx[ch] = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            rx[ch] = b[i];
            tick(16);
        end
        rx[ch] = stop_bit;
        tick(16);
        rx[ch] = 1'b1;
        tick(4);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic       h;
        logic [7:0] b;
        logic       exp_bit;
        int         p;
        int         t;
        int         lows;
        logic [9:0] frame;

        reset_n  = 1'b0;
        address  = 19'h0;
        write_en = 1'b0;
        data_in  = 8'h00;
        rx       = 4'hF;
        tick(3);
        check("tx during reset", tx, 4'hF);
        reset_n = 1'b1;
        tick(2);

        // Reset state and address decode
        bus_read(19'h3f200, rd, h);
        check("ch0 status reset", rd, 8'h06);
        check("hit base", h, 1'b1);
        bus_read(19'h3f1ff, rd, h);
        check("hit below base", h, 1'b0);
        check("data below base", rd, 8'h00);
        bus_read(19'h3f207, rd, h);
        check("hit last", h, 1'b1);
        check("ch3 data reset", rd, 8'h00);
        bus_read(19'h3f208, rd, h);
        check("hit above last", h, 1'b0);
        bus_read(19'h3f206, rd, h);
        check("ch3 status reset", rd, 8'h06);
        check("tx idle after reset", tx, 4'hF);

        // Single frame on channel 0: 8'h48
        tick(1);
        bus_write(19'h3f201, 8'h48);
        check("ch0 tx before N+1", tx[0], 1'b1);
        bus_read(19'h3f200, rd, h);
        check("ch0 status queued", rd, 8'h02);
        tick(1);
        frame = {1'b1, 8'h48, 1'b0};
        for (int k = 0; k < 10; k++) begin
            check($sformatf("ch0 bit%0d first", k), tx[0], frame[k]);
            tick(15);
            check($sformatf("ch0 bit%0d last", k), tx[0], frame[k]);
            if (k == 9) begin
                bus_read(19'h3f200, rd, h);
                check("ch0 status in stop", rd, 8'h02);
            end
            tick(1);
        end
        check("ch0 tx after frame", tx[0], 1'b1);
        bus_read(19'h3f200, rd, h);
        check("ch0 tx_idle back", rd, 8'h06);
        check("other tx idle", tx[3:1], 3'b111);

        // Channel 1 burst: first byte leaves the FIFO at once, so 17 fit and the 18th drops
        for (int i = 0; i < 18; i++) begin
            bus_write(19'h3f203, 8'(8'h30 + i));
            if (i == 16) begin
                bus_read(19'h3f202, rd, h);
                check("ch1 full no overflow", rd, 8'h00);
            end
        end
        p = 17;
        bus_read(19'h3f202, rd, h);
        check("ch1 overflow set", rd, 8'h10);
        bus_write(19'h3f202, 8'h10);
        p = 18;
        bus_read(19'h3f202, rd, h);
        check("ch1 overflow cleared", rd, 8'h00);
        for (int f = 0; f < 17; f++) begin
            b = 8'(8'h30 + f);
            for (int k = 0; k < 10; k++) begin
                t = 1 + 160 * f + 16 * k + 8;
                if (t > p) begin
                    tick(t - p);
                    p = t;
                    exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
                    check($sformatf("ch1 frame%0d bit%0d", f, k), tx[1], exp_bit);
                end
            end
        end
        tick(2720 - p);
        bus_read(19'h3f202, rd, h);
        check("ch1 last stop status", rd, 8'h02);
        tick(1);
        bus_read(19'h3f202, rd, h);
        check("ch1 drained status", rd, 8'h06);
        check("ch1 tx idle", tx[1], 1'b1);
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (tx[1] == 1'b0) lows++;
        end
        check("ch1 no dropped byte sent", lows, 0);

`ifdef MUX_UART_RX_EN
        // Receiver on channel 2
        send_rx(2, 8'hA5, 1'b1);
        bus_read(19'h3f204, rd, h);
        check("ch2 rx_ready", rd, 8'h07);
        bus_read(19'h3f205, rd, h);
        check("ch2 rx data A5", rd, 8'hA5);
        send_rx(2, 8'h3C, 1'b1);
        bus_read(19'h3f204, rd, h);
        check("ch2 overrun", rd, 8'h0F);
        bus_read(19'h3f205, rd, h);
        check("ch2 rx data 3C", rd, 8'h3C);
        bus_write(19'h3f204, 8'h09);
        bus_read(19'h3f204, rd, h);
        check("ch2 ack", rd, 8'h06);
        bus_read(19'h3f205, rd, h);
        check("ch2 data kept after ack", rd, 8'h3C);
        send_rx(2, 8'h55, 1'b0);
        bus_read(19'h3f204, rd, h);
        check("ch2 framing", rd, 8'h27);
        bus_read(19'h3f205, rd, h);
        check("ch2 rx data 55", rd, 8'h55);
        bus_write(19'h3f204, 8'h21);
        bus_read(19'h3f204, rd, h);
        check("ch2 framing cleared", rd, 8'h06);
        rx[2] = 1'b0;
        tick(3);
        rx[2] = 1'b1;
        tick(200);
        bus_read(19'h3f204, rd, h);
        check("ch2 glitch ignored", rd, 8'h06);
`endif

        // Reset mid-frame on channel 3
        tick(1);
        bus_write(19'h3f207, 8'h00);
        bus_write(19'h3f207, 8'hFF);
        tick(19);
        check("ch3 data bit low", tx[3], 1'b0);
        reset_n = 1'b0;
        #1;
        check("ch3 tx high on reset", tx, 4'hF);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        bus_read(19'h3f206, rd, h);
        check("ch3 status after reset", rd, 8'h06);
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (tx[3] == 1'b0) lows++;
        end
        check("ch3 no residual bytes", lows, 0);
        check("all tx idle at end", tx, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
